mem_io_router: RTL and testbench
================================

Name: mem_io_router

Overview:
- Single-master, multi-target transaction router between the CPU memory port and the backing targets.
- Targets are one main memory and NCH I/O devices. Each transaction is decoded to exactly one target by address.
- Registers the request, drives a strobe/rw/ready handshake to the chosen target and returns read data with a one-cycle ready pulse.
- Sits between cpu_cache_tlb and physical_memory/devices. Generalises the fixed two-way mem/io split to N channels, with error reporting and an optional timeout.

Parameters:
- NCH, 4, number of I/O channels (1..16).
- SELW, 2, channel-select width; must satisfy 2**SELW >= NCH.
- IO_TOP, 4'hA, value of a[31:28] that selects the I/O region.
- SEL_LSB, 8, LSB of the channel-select field a[SEL_LSB +: SELW].
- TIMEOUT, 255, cycles BUSY may last before forced completion; used only with the optional feature.

Ports:
- clk  in  1  clock
- clr  in  1  reset, asynchronous, active-high
- m_a  in  32  master address
- m_d_w  in  32  master write data
- m_access  in  1  master request strobe
- m_write  in  1  1 = write
- m_d_r  out  32  read data, valid while m_ready=1
- m_ready  out  1  one-cycle completion pulse
- m_err  out  1  error flag, valid while m_ready=1
- mem_a  out  32  latched address to memory
- mem_din  out  32  latched write data to memory
- mem_strobe  out  1  memory request
- mem_rw  out  1  memory write
- mem_dout  in  32  memory read data
- mem_ready  in  1  memory done
- io_a  out  32  latched address to I/O, shared by all channels
- io_din  out  32  latched write data to I/O, shared by all channels
- io_strobe  out  NCH  one-hot channel request
- io_rw  out  1  I/O write
- io_dout  in  32*NCH  per-channel read data; channel k occupies [32k+31:32k]
- io_ready  in  NCH  per-channel done

Behaviour:
- Reset (clr=1, asynchronous):
  - state=IDLE.
  - All strobes, m_ready and m_err are 0.
  - m_d_r, latched address and latched data are 0.
  - Reset during BUSY drops strobes immediately. No completion is issued.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If m_access=1 at an edge: latch a, d, write; decode target; go to BUSY.
  - Decode when a[31:28]==IO_TOP: target is channel ch=a[SEL_LSB+:SELW]. Otherwise target is memory.
  - If ch >= NCH: go directly to DONE with m_err=1 and m_d_r=0. No strobe is asserted.
- BUSY:
  - Exactly one of mem_strobe / io_strobe[ch] is high.
  - rw equals the latched write bit. Address and data are stable throughout.
  - When the selected target's ready=1 at an edge: capture its read data (writes capture 0); m_err=0; go to DONE.
  - Ready inputs from non-selected targets are ignored.
- DONE:
  - m_ready=1 for exactly one cycle, all strobes 0, then IDLE.
  - The master must deassert m_access in the cycle following m_ready. If m_access is still high in IDLE, a new transaction starts.
- Latency:
  - A zero-wait target (ready high in the first BUSY cycle) completes with m_ready high 2 cycles after the request edge.
  - Each wait cycle adds 1.
- m_d_r holds its last value outside DONE.
- m_access changes during BUSY are ignored.
- Only one transaction is outstanding at a time. There is no pipelining.

Optional Feature:
- Macro: MEM_IO_ROUTER_TIMEOUT_EN.
- With the macro:
  - A counter clears on entering BUSY and increments each BUSY cycle.
  - When the count reaches TIMEOUT with no ready, the router drops the strobe, goes to DONE, and reports m_err=1 and m_d_r=32'hDEADBEEF.
  - A ready arriving in the same cycle as the timeout wins (normal completion, m_err=0).
- Without the macro: no counter exists, and BUSY waits indefinitely for ready.

Test Plan:
- Memory read, a=0x0000_0040, mem_ready high on the 3rd BUSY cycle, mem_dout=0x1234_5678 → mem_strobe high for exactly 3 cycles with mem_rw=0; m_ready pulses once with m_d_r=0x1234_5678, m_err=0.
- I/O write, a=0xA000_0200, d=0xCAFE_F00D, io_ready[2] zero-wait → io_strobe=4'b0100 for one cycle with io_rw=1 and io_din=0xCAFE_F00D; m_ready 2 cycles after the request edge; mem_strobe stays 0.
- Unmapped channel, NCH=3, a=0xA000_0300 → no strobe; m_ready with m_err=1, m_d_r=0.
- Spurious readiness: io_ready[1]=1 while memory is busy → ignored; completion only on mem_ready.
- Reset mid-transaction: clr asserted during BUSY → strobes drop asynchronously; no m_ready; next request after release completes normally.
- MEM_IO_ROUTER_TIMEOUT_EN, TIMEOUT=8, device never ready → strobe high 8 cycles, then m_ready with m_err=1, m_d_r=0xDEADBEEF. Repeat with ready on cycle 8 → normal completion.

Source files
------------

// File: rtl/mem_io_router.sv
// Single-master router: decodes each CPU access to main memory or one of NCH I/O channels.
// Optional busy timeout is enabled by defining MEM_IO_ROUTER_TIMEOUT_EN.
module mem_io_router #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned SELW    = 2,
    parameter logic [3:0]  IO_TOP  = 4'hA,
    parameter int unsigned SEL_LSB = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [31:0]         m_a,
    input  logic [31:0]         m_d_w,
    input  logic                m_access,
    input  logic                m_write,
    output logic [31:0]         m_d_r,
    output logic                m_ready,
    output logic                m_err,
    output logic [31:0]         mem_a,
    output logic [31:0]         mem_din,
    output logic                mem_strobe,
    output logic                mem_rw,
    input  logic [31:0]         mem_dout,
    input  logic                mem_ready,
    output logic [31:0]         io_a,
    output logic [31:0]         io_din,
    output logic [NCH-1:0]      io_strobe,
    output logic                io_rw,
    input  logic [32*NCH-1:0]   io_dout,
    input  logic [NCH-1:0]      io_ready
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [SELW:0] NCH_W = NCH[SELW:0];

    logic [1:0]      state_q, state_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     d_q, d_d;
    logic            write_q, write_d;
    logic            io_q, io_d;
    logic [SELW-1:0] ch_q, ch_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            req_io;
    logic [SELW-1:0] req_ch;
    logic            req_unmapped;
    logic            sel_ready;
    logic [31:0]     sel_data;
    logic            busy;

`ifdef MEM_IO_ROUTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign busy         = (state_q == StBusy);
    assign req_io       = (m_a[31:28] == IO_TOP);
    assign req_ch       = m_a[SEL_LSB +: SELW];
    assign req_unmapped = req_io && ({1'b0, req_ch} >= NCH_W);

    // Only the latched target's ready/data are visible; the rest are ignored.
    always_comb begin
        sel_ready = mem_ready;
        sel_data  = mem_dout;
        if (io_q) begin
            sel_ready = 1'b0;
            sel_data  = '0;
            for (int k = 0; k < int'(NCH); k++) begin
                if (ch_q == SELW'(k)) begin
                    sel_ready = io_ready[k];
                    sel_data  = io_dout[32*k +: 32];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        write_d = write_q;
        io_d    = io_q;
        ch_d    = ch_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef MEM_IO_ROUTER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (m_access) begin
                    a_d     = m_a;
                    d_d     = m_d_w;
                    write_d = m_write;
                    io_d    = req_io;
                    ch_d    = req_ch;
`ifdef MEM_IO_ROUTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    if (req_unmapped) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (sel_ready) begin
                    state_d = StDone;
                    err_d   = 1'b0;
                    rdata_d = write_q ? 32'h0 : sel_data;
                end
`ifdef MEM_IO_ROUTER_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    rdata_d = 32'hDEAD_BEEF;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
            a_q     <= '0;
            d_q     <= '0;
            write_q <= 1'b0;
            io_q    <= 1'b0;
            ch_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef MEM_IO_ROUTER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            write_q <= write_d;
            io_q    <= io_d;
            ch_q    <= ch_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef MEM_IO_ROUTER_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        io_strobe = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            io_strobe[k] = busy && io_q && (ch_q == SELW'(k));
        end
    end

    assign mem_strobe = busy && !io_q;
    assign mem_a      = a_q;
    assign mem_din    = d_q;
    assign mem_rw     = write_q;
    assign io_a       = a_q;
    assign io_din     = d_q;
    assign io_rw      = write_q;
    assign m_ready    = (state_q == StDone);
    assign m_err      = m_ready && err_q;
    assign m_d_r      = rdata_q;

endmodule

// File: tb/tb_mem_io_router.sv
// Randomized self-checking bench for mem_io_router (NCH=3 so channel 3 is unmapped).
// Timeout expectations follow MEM_IO_ROUTER_TIMEOUT_EN when it is defined.
module tb_mem_io_router;

    localparam int NCH = 3;
    localparam int TMO = 8;
`ifdef MEM_IO_ROUTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              clr;
    logic [31:0]       m_a, m_d_w;
    logic              m_access, m_write;
    logic [31:0]       m_d_r;
    logic              m_ready, m_err;
    logic [31:0]       mem_a, mem_din, mem_dout;
    logic              mem_strobe, mem_rw, mem_ready;
    logic [31:0]       io_a, io_din;
    logic [NCH-1:0]    io_strobe, io_ready;
    logic              io_rw;
    logic [32*NCH-1:0] io_dout;

    int n_checks = 0;
    int n_errors = 0;

    mem_io_router #(
        .NCH(NCH), .SELW(2), .IO_TOP(4'hA), .SEL_LSB(8), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .clr(clr), .m_a(m_a), .m_d_w(m_d_w), .m_access(m_access),
        .m_write(m_write), .m_d_r(m_d_r), .m_ready(m_ready), .m_err(m_err),
        .mem_a(mem_a), .mem_din(mem_din), .mem_strobe(mem_strobe), .mem_rw(mem_rw),
        .mem_dout(mem_dout), .mem_ready(mem_ready), .io_a(io_a), .io_din(io_din),
        .io_strobe(io_strobe), .io_rw(io_rw), .io_dout(io_dout), .io_ready(io_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One transaction; the model predicts target, strobe span, latency and result from the address.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic wr,
                           input int wait_n, input logic [31:0] rdat);
        logic        is_io, unm, to, exp_err, got_err;
        int          ch, busy_cyc, done_k, bad;
        logic [31:0] exp_d, got_d, exp_stb, stb;
        is_io    = (a >> 28) == 32'hA;
        ch       = int'((a >> 8) & 32'h3);
        unm      = is_io && (ch >= NCH);
        to       = TO_EN && !unm && (wait_n >= TMO);
        busy_cyc = unm ? 0 : (to ? TMO : wait_n + 1);
        exp_err  = unm || to;
        exp_d    = unm ? 32'h0 : (to ? 32'hDEAD_BEEF : (wr ? 32'h0 : rdat));
        exp_stb  = unm ? 32'h0 : (is_io ? (32'h2 << ch) : 32'h1);
        done_k   = 0;
        bad      = 0;
        got_err  = 1'b0;
        got_d    = '0;

        @(negedge clk);
        m_a = a; m_d_w = d; m_write = wr; m_access = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= busy_cyc + 12 && done_k == 0; k++) begin
            @(negedge clk);
            stb = 32'({io_strobe, mem_strobe});
            if (stb !== ((k <= busy_cyc) ? exp_stb : 32'h0)) bad++;
            if (stb != 0 && (mem_a !== a || io_a !== a || mem_din !== d || io_din !== d
                             || mem_rw !== wr || io_rw !== wr)) bad++;
            if (m_ready) begin
                done_k = k;
                got_d = m_d_r;
                got_err = m_err;
                m_access = 1'b0;
                mem_ready = 1'b0;
                io_ready = '0;
            end else begin
                // Noise on everything the router must ignore while busy.
                mem_ready = 1'($urandom);
                io_ready  = NCH'($urandom);
                mem_dout  = $urandom;
                io_dout   = {$urandom, $urandom, $urandom};
                m_a = $urandom; m_d_w = $urandom; m_write = 1'($urandom);
                m_access = 1'($urandom);
                if (!unm) begin
                    if (is_io) begin
                        io_ready[ch] = (k == wait_n + 1);
                        if (k == wait_n + 1) io_dout[32*ch +: 32] = rdat;
                    end else begin
                        mem_ready = (k == wait_n + 1);
                        if (k == wait_n + 1) mem_dout = rdat;
                    end
                end
            end
        end
        check("latency", 32'(done_k), 32'(busy_cyc + 1));
        check("rdata", got_d, exp_d);
        check("err", 32'(got_err), 32'(exp_err));
        check("strobe_seq", 32'(bad), 32'h0);
        @(negedge clk);
        check("ready_pulse", 32'(m_ready), 32'h0);
        check("rdata_hold", m_d_r, exp_d);
    endtask

    task automatic reset_mid_busy();
        @(negedge clk);
        m_a = 32'hA000_0100; m_d_w = 32'h1; m_write = 1'b0; m_access = 1'b1;
        mem_ready = 1'b0; io_ready = '0;
        @(posedge clk);
        @(negedge clk);
        m_access = 1'b0;
        check("rst_pre_strobe", 32'(io_strobe), 32'h2);
        @(posedge clk);
        #2 clr = 1'b1;
        #1;
        check("rst_strobe_drop", 32'({io_strobe, mem_strobe}), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_no_ready", 32'(m_ready), 32'h0);
        end
        clr = 1'b0;
        check("rst_clears_a", io_a, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        int          wn;
        clr = 1'b1;
        m_a = '0; m_d_w = '0; m_access = 1'b0; m_write = 1'b0;
        mem_dout = '0; mem_ready = 1'b0; io_dout = '0; io_ready = '0;
        #23;
        check("reset_strobes", 32'({io_strobe, mem_strobe}), 32'h0);
        check("reset_ready", 32'({m_ready, m_err}), 32'h0);
        check("reset_rdata", m_d_r, 32'h0);
        check("reset_addr", mem_a, 32'h0);
        check("reset_din", io_din, 32'h0);
        @(negedge clk);
        clr = 1'b0;

        run_txn(32'h0000_0040, 32'h0, 1'b0, 2, 32'h1234_5678);
        run_txn(32'hA000_0200, 32'hCAFE_F00D, 1'b1, 0, 32'h5555_AAAA);
        run_txn(32'hA000_0300, 32'h0, 1'b0, 0, 32'h0);
        run_txn(32'hA000_0100, 32'h0, 1'b0, 4, 32'h0BAD_F00D);
        reset_mid_busy();
        run_txn(32'h1000_0004, 32'h0, 1'b0, 1, 32'h8765_4321);
        run_txn(32'hA000_0000, 32'h0, 1'b0, TMO - 1, 32'h7777_0000);
        run_txn(32'h2000_0000, 32'h0, 1'b0, TMO + 4, 32'h3333_4444);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[31:28] = 4'hA;
            else if (a[31:28] == 4'hA) a[31:28] = 4'h0;
            wn = ($urandom_range(0, 7) == 0) ? 10 : int'($urandom_range(0, 4));
            run_txn(a, $urandom, 1'($urandom), wn, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
